// File: rtl/mem_responder_if.sv
// mem_responder_if: controller memory bus plus loader write port
interface mem_responder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  msel;
  logic                  mwrite;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] b_data;
  logic [DATA_WIDTH-1:0] mdata;
  logic                  ld_valid;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_ready;
  modport master (
    output msel, mwrite, pc, c_addr, b_data, ld_valid, ld_addr, ld_data,
    input  mdata, ld_ready
  );
  modport slave (
    input  msel, mwrite, pc, c_addr, b_data, ld_valid, ld_addr, ld_data,
    output mdata, ld_ready
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: RAM + switch/LED MMIO with 1-cycle registered reads and a preload port
module mem_responder #(
  parameter int                   DATA_WIDTH = 16,
  parameter int                   ADDR_WIDTH = 8,
  parameter int                   RAM_DEPTH  = 128,
  parameter logic [ADDR_WIDTH-1:0] SW_ADDR   = 8'h80,
  parameter logic [ADDR_WIDTH-1:0] LED_ADDR  = 8'h81
) (
  input  logic             clk,
  input  logic             reset,
  mem_responder_if.slave   bus,
  input  logic [7:0]       sw,
  output logic [7:0]       led,
  output logic             fault
);
  localparam int RAW = $clog2(RAM_DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH = RAM_DEPTH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] ram [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] mdata_q, mdata_d;
  logic [7:0]            led_q, led_d, sw_meta_q, sw_sync_q;
  logic                  fault_q, fault_d;
  logic [ADDR_WIDTH-1:0] ea;
  logic                  in_ram, is_sw, is_led, ld_in_ram, ram_we;
  logic [RAW-1:0]        ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;

  always_comb begin
    ea          = bus.msel ? bus.c_addr : bus.pc;
    in_ram      = {1'b0, ea} < DEPTH;
    is_sw       = ea == SW_ADDR;
    is_led      = ea == LED_ADDR;
    ld_in_ram   = {1'b0, bus.ld_addr} < DEPTH;
    bus.ld_ready = bus.ld_valid & ~bus.mwrite;
    mdata_d     = bus.mwrite ? mdata_q :
                  in_ram     ? ram[ea[RAW-1:0]] :
                  is_sw      ? DATA_WIDTH'(sw_sync_q) :
                  is_led     ? DATA_WIDTH'(led_q) : '0;
    led_d       = (bus.mwrite & is_led) ? bus.b_data[7:0] : led_q;
    // SW is readable but not writable; anything outside RAM/SW/LED always faults
    fault_d     = fault_q | (~in_ram & ~is_led & (bus.mwrite | ~is_sw))
                          | (bus.ld_ready & ~ld_in_ram);
    ram_we      = (bus.mwrite & in_ram) | (bus.ld_ready & ld_in_ram);
    ram_waddr   = bus.mwrite ? ea[RAW-1:0] : bus.ld_addr[RAW-1:0];
    ram_wdata   = bus.mwrite ? bus.b_data : bus.ld_data;
  end

  always_ff @(posedge clk)
    if (ram_we) ram[ram_waddr] <= ram_wdata;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mdata_q   <= '0;
      led_q     <= '0;
      fault_q   <= 1'b0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      mdata_q   <= mdata_d;
      led_q     <= led_d;
      fault_q   <= fault_d;
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end

  assign bus.mdata = mdata_q;
  assign led       = led_q;
  assign fault     = fault_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table-driven vectors with a scoreboard queue of expected outputs
module tb_mem_responder;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sw, led;
  logic       fault;
  int         checks = 0;
  int         errors = 0;

  mem_responder_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus ();

  mem_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .sw    (sw),
    .led   (led),
    .fault (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rb;
    logic        sel, wr;
    logic [7:0]  pc, ca;
    logic [15:0] bd;
    logic        lv;
    logic [7:0]  la;
    logic [15:0] ld;
    logic [7:0]  sw;
    logic        rdy;
    logic [15:0] md;
    logic [7:0]  led;
    logic        flt;
  } vec_t;

  typedef struct {
    logic [15:0] md;
    logic [7:0]  led;
    logic        flt;
    int          idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];

  function automatic vec_t mk(bit rb, logic sel, logic wr, logic [7:0] pc, logic [7:0] ca,
                              logic [15:0] bd, logic lv, logic [7:0] la, logic [15:0] ld,
                              logic [7:0] s, logic rdy, logic [15:0] md, logic [7:0] l,
                              logic flt);
    vec_t v;
    v.rb = rb; v.sel = sel; v.wr = wr; v.pc = pc; v.ca = ca; v.bd = bd;
    v.lv = lv; v.la = la; v.ld = ld; v.sw = s;
    v.rdy = rdy; v.md = md; v.led = l; v.flt = flt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.msel = 1'b1; bus.mwrite = 1'b0; bus.pc = 8'h00; bus.c_addr = 8'h81;
    bus.b_data = 16'h0000; bus.ld_valid = 1'b0; bus.ld_addr = 8'h00; bus.ld_data = 16'h0000;
  endtask

  task automatic mid_reset(input int idx);
    @(negedge clk);
    idle_inputs();
    #2 reset = 1'b1;
    #1;
    chk($sformatf("async_rst_mdata[%0d]", idx), bus.mdata, 16'h0000);
    chk($sformatf("async_rst_led[%0d]", idx), 16'(led), 16'h0000);
    chk($sformatf("async_rst_fault[%0d]", idx), 16'(fault), 16'h0000);
    #1 reset = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    if (v.rb) mid_reset(idx);
    @(negedge clk);
    bus.msel = v.sel; bus.mwrite = v.wr; bus.pc = v.pc; bus.c_addr = v.ca;
    bus.b_data = v.bd; bus.ld_valid = v.lv; bus.ld_addr = v.la; bus.ld_data = v.ld;
    sw = v.sw;
    #1 chk($sformatf("ld_ready[%0d]", idx), 16'(bus.ld_ready), 16'(v.rdy));
    e.md = v.md; e.led = v.led; e.flt = v.flt; e.idx = idx;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty[%0d] actual=0 expected=1", idx);
    end else begin
      e = sbq.pop_front();
      chk($sformatf("mdata[%0d]", e.idx), bus.mdata, e.md);
      chk($sformatf("led[%0d]", e.idx), 16'(led), 16'(e.led));
      chk($sformatf("fault[%0d]", e.idx), 16'(fault), 16'(e.flt));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //                 rb sel wr pc     ca     bd        lv la     ld        sw     rdy md        led    flt
    vecs.push_back(mk(0, 1, 0, 8'h00, 8'h81, 16'h0000, 1, 8'h00, 16'hD105, 8'h00, 1, 16'h0000, 8'h00, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8'h81, 16'h0000, 1, 8'h01, 16'hA04A, 8'h00, 1, 16'h0000, 8'h00, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8'h81, 16'h0000, 1, 8'h70, 16'h7777, 8'h00, 1, 16'h0000, 8'h00, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h81, 16'h0000, 0, 8'h00, 16'h0000, 8'h00, 0, 16'hD105, 8'h00, 0));
    vecs.push_back(mk(0, 0, 0, 8'h01, 8'h81, 16'h0000, 0, 8'h00, 16'h0000, 8'h00, 0, 16'hA04A, 8'h00, 0));
    vecs.push_back(mk(0, 1, 1, 8'h00, 8'h10, 16'h1234, 0, 8'h00, 16'h0000, 8'h00, 0, 16'hA04A, 8'h00, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8'h10, 16'h0000, 0, 8'h00, 16'h0000, 8'h00, 0, 16'h1234, 8'h00, 0));
    vecs.push_back(mk(0, 1, 1, 8'h00, 8'h81, 16'hFFA5, 0, 8'h00, 16'h0000, 8'h00, 0, 16'h1234, 8'hA5, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8'h81, 16'h0000, 0, 8'h00, 16'h0000, 8'h00, 0, 16'h00A5, 8'hA5, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8'h80, 16'h0000, 0, 8'h00, 16'h0000, 8'h3C, 0, 16'h0000, 8'hA5, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8'h80, 16'h0000, 0, 8'h00, 16'h0000, 8'h3C, 0, 16'h0000, 8'hA5, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8'h80, 16'h0000, 0, 8'h00, 16'h0000, 8'h3C, 0, 16'h003C, 8'hA5, 0));
    vecs.push_back(mk(0, 1, 1, 8'h00, 8'h05, 16'h0001, 1, 8'h05, 16'hBEEF, 8'h3C, 0, 16'h003C, 8'hA5, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8'h05, 16'h0000, 1, 8'h05, 16'hBEEF, 8'h3C, 1, 16'h0001, 8'hA5, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8'h05, 16'h0000, 0, 8'h00, 16'h0000, 8'h3C, 0, 16'hBEEF, 8'hA5, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h81, 16'h0000, 0, 8'h00, 16'h0000, 8'h00, 0, 16'hD105, 8'hA5, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8'hC0, 16'h0000, 0, 8'h00, 16'h0000, 8'h00, 0, 16'h0000, 8'hA5, 1));
    vecs.push_back(mk(0, 0, 0, 8'h01, 8'h81, 16'h0000, 0, 8'h00, 16'h0000, 8'h00, 0, 16'hA04A, 8'hA5, 1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 8'h81, 16'h0000, 0, 8'h00, 16'h0000, 8'h00, 0, 16'hD105, 8'h00, 0));
    vecs.push_back(mk(0, 1, 1, 8'h00, 8'h80, 16'hFFFF, 0, 8'h00, 16'h0000, 8'h00, 0, 16'hD105, 8'h00, 1));
    vecs.push_back(mk(1, 1, 0, 8'h00, 8'h81, 16'h0000, 1, 8'hF0, 16'h5555, 8'h00, 1, 16'h0000, 8'h00, 1));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8'h70, 16'h0000, 0, 8'h00, 16'h0000, 8'h00, 0, 16'h7777, 8'h00, 1));
    vecs.push_back(mk(1, 1, 0, 8'h00, 8'h70, 16'h0000, 0, 8'h00, 16'h0000, 8'h00, 0, 16'h7777, 8'h00, 0));
    vecs.push_back(mk(0, 1, 1, 8'h00, 8'hC0, 16'h1111, 0, 8'h00, 16'h0000, 8'h00, 0, 16'h7777, 8'h00, 1));
    vecs.push_back(mk(1, 1, 0, 8'h00, 8'h81, 16'h0000, 1, 8'h7F, 16'h4242, 8'h00, 1, 16'h0000, 8'h00, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8'h7F, 16'h0000, 0, 8'h00, 16'h0000, 8'h00, 0, 16'h4242, 8'h00, 0));

    idle_inputs();
    sw = 8'h00;
    reset = 1'b1;
    #3;
    chk("reset_mdata", bus.mdata, 16'h0000);
    chk("reset_led", 16'(led), 16'h0000);
    chk("reset_fault", 16'(fault), 16'h0000);
    chk("reset_ld_ready", 16'(bus.ld_ready), 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
